// File: rtl/wired_rf_wb_arbiter.sv
// Per-requester writeback FIFOs drained round-robin onto the register-file write port; optional pending lookup (WIRED_RF_WB_PENDING_EN).
// Latency: push at T -> granted T+1 -> rf_wea_o high during T+2; one RAM write per cycle.
// Backpressure: req_ready_o drops while a requester FIFO is full; a pop does not free a slot in the same cycle.
module wired_rf_wb_arbiter #(
   parameter int WIDTH      = 32,
   parameter int REQ_NUM    = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [REQ_NUM-1:0]         req_valid_i,
   output logic [REQ_NUM-1:0]         req_ready_o,
   input  logic [REQ_NUM*6-1:0]       req_addr_i,
   input  logic [REQ_NUM*WIDTH-1:0]   req_data_i,
   output logic                       rf_wea_o,
   output logic [5:0]                 rf_addrw_o,
   output logic [WIDTH-1:0]           rf_din_o,
   input  logic [7*6-1:0]             qry_addr_i,
   output logic [6:0]                 qry_pending_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = $clog2(REQ_NUM);

   logic [5:0]       fifo_addr [REQ_NUM][FIFO_DEPTH];
   logic [WIDTH-1:0] fifo_data [REQ_NUM][FIFO_DEPTH];
   logic [PW-1:0]    rd_ptr [REQ_NUM];
   logic [PW-1:0]    wr_ptr [REQ_NUM];
   logic [CW-1:0]    cnt    [REQ_NUM];
   logic [REQ_NUM-1:0] push;
   logic [REQ_NUM-1:0] pop;
   logic [RW-1:0]    rr;
   logic [RW-1:0]    gnt_idx;
   logic             gnt_vld;
   int               cand;
   logic [5:0]       head_addr;
   logic [WIDTH-1:0] head_data;

   for (genvar r = 0; r < REQ_NUM; r++) begin : g_req
      assign req_ready_o[r] = (cnt[r] != CW'(FIFO_DEPTH));
      assign push[r]        = req_valid_i[r] & req_ready_o[r];
      assign pop[r]         = gnt_vld && (gnt_idx == RW'(r));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < REQ_NUM; r++) begin
            rd_ptr[r] <= '0;
            wr_ptr[r] <= '0;
            cnt[r]    <= '0;
         end
      end else begin
         for (int r = 0; r < REQ_NUM; r++) begin
            if (push[r]) wr_ptr[r] <= wr_ptr[r] + PW'(1);
            if (pop[r])  rd_ptr[r] <= rd_ptr[r] + PW'(1);
            if (push[r] && !pop[r])      cnt[r] <= cnt[r] + CW'(1);
            else if (pop[r] && !push[r]) cnt[r] <= cnt[r] - CW'(1);
         end
      end
   end

   // Storage needs no reset: occupancy alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      for (int r = 0; r < REQ_NUM; r++) begin
         if (push[r]) begin
            fifo_addr[r][wr_ptr[r]] <= req_addr_i[r*6 +: 6];
            fifo_data[r][wr_ptr[r]] <= req_data_i[r*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int i = 0; i < REQ_NUM; i++) begin
         cand = (int'(rr) + i) % REQ_NUM;
         if (!gnt_vld && cnt[cand] != '0) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[RW-1:0];
         end
      end
   end

   always_comb begin
      head_addr = fifo_addr[0][rd_ptr[0]];
      head_data = fifo_data[0][rd_ptr[0]];
      for (int r = 1; r < REQ_NUM; r++) begin
         if (gnt_idx == RW'(r)) begin
            head_addr = fifo_addr[r][rd_ptr[r]];
            head_data = fifo_data[r][rd_ptr[r]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr         <= '0;
         rf_wea_o   <= 1'b0;
         rf_addrw_o <= '0;
         rf_din_o   <= '0;
      end else begin
         rf_wea_o <= gnt_vld;
         if (gnt_vld) begin
            rr         <= (gnt_idx == RW'(REQ_NUM - 1)) ? '0 : gnt_idx + RW'(1);
            rf_addrw_o <= head_addr;
            rf_din_o   <= head_data;
         end
      end
   end

`ifdef WIRED_RF_WB_PENDING_EN
   logic ent_vld [REQ_NUM][FIFO_DEPTH];

   // Slot j is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      for (int r = 0; r < REQ_NUM; r++) begin
         for (int j = 0; j < FIFO_DEPTH; j++) begin
            ent_vld[r][j] = ({1'b0, PW'(j) - rd_ptr[r]} < cnt[r]);
         end
      end
   end

   always_comb begin
      qry_pending_o = '0;
      for (int k = 0; k < 7; k++) begin
         if (rf_wea_o && rf_addrw_o == qry_addr_i[k*6 +: 6]) qry_pending_o[k] = 1'b1;
         for (int r = 0; r < REQ_NUM; r++) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
               if (ent_vld[r][j] && fifo_addr[r][j] == qry_addr_i[k*6 +: 6]) qry_pending_o[k] = 1'b1;
            end
         end
      end
   end
`else
   logic unused_qry;
   assign unused_qry    = ^qry_addr_i;
   assign qry_pending_o = '0;
`endif

endmodule
